// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants and types for the inverse key schedule
package aes_pkg;
  typedef logic [3:0]   round_t;
  typedef logic [0:127] key_t;
  typedef enum logic {IDLE, RUN} state_e;
  localparam round_t NR = 4'd10;
  localparam logic [31:0] RCON [10] = '{
    32'h01000000, 32'h02000000, 32'h04000000, 32'h08000000, 32'h10000000,
    32'h20000000, 32'h40000000, 32'h80000000, 32'h1b000000, 32'h36000000
  };
endpackage

// File: rtl/sbox.sv
// sbox: forward AES S-box, input byte given as high and low nibble
module sbox (
  input  logic [3:0] hi_i,
  input  logic [3:0] lo_i,
  output logic [7:0] s_o
);
  localparam logic [0:2047] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign s_o = TBL[{hi_i, lo_i, 3'b000} +: 8];
endmodule

// File: rtl/inv_key_sched.sv
// inv_key_sched: walks AES-128 round keys backwards 10..0; INV_KSCHED_STALL_EN adds rk_ready backpressure
module inv_key_sched
  import aes_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
`ifdef INV_KSCHED_STALL_EN
  input  logic   rk_ready,
`endif
  input  key_t   key_last,
  output logic   busy,
  output logic   rk_valid,
  output key_t   rk,
  output round_t rk_round,
  output logic   rk_last
);
  state_e      state_q, state_d;
  key_t        key_q, key_d, prev_key;
  round_t      round_q, round_d;
  logic        run, adv;
  logic [0:31] p0, p1, p2, p3, sw;
  logic [31:0] rc;
  assign run = state_q == RUN;
`ifdef INV_KSCHED_STALL_EN
  assign adv = run & rk_ready;
`else
  assign adv = run;
`endif
  assign p3 = key_q[96:127] ^ key_q[64:95];
  assign p2 = key_q[64:95] ^ key_q[32:63];
  assign p1 = key_q[32:63] ^ key_q[0:31];
  assign rc = (round_q == '0) ? '0 : RCON[round_q - 4'd1];
  for (genvar g = 0; g < 4; g++) begin : g_sub
    sbox u_sbox (
      .hi_i(p3[8*((g+1)%4) +: 4]),
      .lo_i(p3[8*((g+1)%4)+4 +: 4]),
      .s_o (sw[8*g +: 8])
    );
  end
  assign p0 = key_q[0:31] ^ sw ^ rc;
  assign prev_key = {p0, p1, p2, p3};
  // state, key and round registers; reset abandons any walk in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end
  // load on start from IDLE only, then step one round back per accepted key
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    if (!run) begin
      if (start) begin
        state_d = RUN;
        key_d   = key_last;
        round_d = NR;
      end
    end else if (adv) begin
      if (round_q == '0) state_d = IDLE;
      else begin
        key_d   = prev_key;
        round_d = round_q - 4'd1;
      end
    end
  end
  assign busy     = run;
  assign rk_valid = run;
  assign rk       = key_q;
  assign rk_round = round_q;
  assign rk_last  = run & (round_q == '0);
endmodule

// File: tb/tb_inv_key_sched.sv
// tb_inv_key_sched: random and directed walks checked against a forward key expansion model
module tb_inv_key_sched;
  import aes_pkg::*;
  logic   clk = 0, rst = 0, start = 0, rk_ready = 1;
  key_t   key_last = '0, rk;
  logic   busy, rk_valid, rk_last;
  round_t rk_round;
  int     nvec = 0, nerr = 0;
  logic [7:0] sb [256];
  key_t   pend [11];
  key_t   cur [11];
  int     er = 0;
  logic   act = 0, clr = 1;

  always #5 clk = ~clk;

  inv_key_sched dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef INV_KSCHED_STALL_EN
    .rk_ready(rk_ready),
`endif
    .key_last(key_last), .busy(busy), .rk_valid(rk_valid),
    .rk(rk), .rk_round(rk_round), .rk_last(rk_last)
  );

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", n, a, e);
    end
  endtask

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] v;
      v = 0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      sb[x] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    end
  endtask

  task automatic prep(input key_t k0);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int j = 0; j < 4; j++) w[j] = k0[32*j +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) pend[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      act <= 0;
      clr <= 1;
    end else if (!act) begin
      if (start) begin
        act <= 1;
        clr <= 0;
        er  <= 10;
        cur <= pend;
      end
    end else if (rk_ready) begin
      if (er == 0) act <= 0;
      else er <= er - 1;
    end
  end

  always @(negedge clk) begin
    if (rst || clr) begin
      chk("rst_busy", busy, 0);
      chk("rst_valid", rk_valid, 0);
      chk("rst_rk", rk, 0);
      chk("rst_round", rk_round, 0);
      chk("rst_last", rk_last, 0);
    end else if (act) begin
      chk("run_valid", rk_valid, 1);
      chk("run_busy", busy, 1);
      chk("run_round", rk_round, er);
      chk("run_rk", rk, cur[er]);
      chk("run_last", rk_last, er == 0);
    end else begin
      chk("idle_valid", rk_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_last", rk_last, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic go(input key_t k0);
    prep(k0);
    key_last = pend[10];
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_round(input int r);
    int n;
    n = 0;
    while (!(rk_valid && rk_round == 4'(r)) && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("timeout_round", rk_round, r);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
`ifdef INV_KSCHED_STALL_EN
      rk_ready = $urandom_range(0, 3) != 0;
`endif
      tick();
      n++;
    end
    rk_ready = 1;
    if (n >= 100) chk("timeout_idle", busy, 0);
  endtask

  function automatic key_t rkey();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int n;
    build_sbox();
    chk("sbox_00", sb[8'h00], 8'h63);
    chk("sbox_53", sb[8'h53], 8'hed);
    #1 rst = 1;
    tick();
    tick();
    rst = 0;
    tick();
    tick();
    prep(128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("model_r10", pend[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model_r9", pend[9], 128'hac7766f319fadc2128d12941575c006e);
    chk("model_r1", pend[1], 128'ha0fafe1788542cb123a339392a6c7605);
    go(128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("fips_r10", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick();
    chk("fips_r9", rk, 128'hac7766f319fadc2128d12941575c006e);
    n = 1;
    while (!rk_last && n < 30) begin
      tick();
      n++;
    end
    chk("fips_latency", n, 10);
    chk("fips_r0", rk, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    wait_idle();
    prep('0);
    chk("zero_r1", pend[1], 128'h62636363626363636263636362636363);
    go('0);
    wait_round(0);
    chk("zero_r0", rk, 0);
    wait_idle();
    go(rkey());
    wait_round(5);
    key_last = rkey();
    start = 1;
    tick();
    tick();
    start = 0;
    wait_round(0);
    start = 1;
    tick();
    start = 0;
    chk("busy_drop", busy, 0);
    tick();
    chk("start_ignored", busy, 0);
    go(rkey());
    wait_round(6);
    #1 rst = 1;
    #1;
    chk("async_valid", rk_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_rk", rk, 0);
    chk("async_round", rk_round, 0);
    tick();
    rst = 0;
    tick();
    go(rkey());
    chk("restart_round", rk_round, 10);
    wait_idle();
`ifdef INV_KSCHED_STALL_EN
    go(rkey());
    wait_round(4);
    rk_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_round", rk_round, 4);
      chk("stall_rk", rk, cur[4]);
    end
    rk_ready = 1;
    tick();
    chk("resume_round", rk_round, 3);
    wait_idle();
`endif
    go(rkey());
    wait_idle();
    go(rkey());
    chk("b2b_round", rk_round, 10);
    chk("b2b_rk", rk, pend[10]);
    wait_idle();
    for (int w = 0; w < 12; w++) begin
      go(rkey());
      wait_idle();
    end
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
